// File: rtl/saber_coeff_pkg.sv
// Shared constants and helpers for the coefficient streaming datapath.
// Holds default widths, mode encoding and a constant-foldable clog2.
package saber_coeff_pkg;

    localparam int COEFF_W  = 13;
    localparam int NARROW_W = 10;
    localparam int NUM_WIDE = 13;

    localparam logic MODE_WIDE   = 1'b0;
    localparam logic MODE_NARROW = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/coeff_select_mux.sv
// Picks one coefficient out of a packed word by slot index and packing mode.
// Narrow coefficients are zero-extended to the full coefficient width.
module coeff_select_mux
    import saber_coeff_pkg::MODE_NARROW;
#(
    parameter int COEFF_W    = 13,
    parameter int NARROW_W   = 10,
    parameter int NUM_WIDE   = 13,
    parameter int DATA_W     = NUM_WIDE * COEFF_W,
    parameter int NUM_NARROW = DATA_W / NARROW_W,
    parameter int CNT_W      = 4
) (
    input  logic [DATA_W-1:0]  word,
    input  logic [CNT_W-1:0]   idx,
    input  logic               mode,
    output logic [COEFF_W-1:0] coeff
);

    always_comb begin
        coeff = '0;
        if (mode == MODE_NARROW) begin
            for (int k = 0; k < NUM_NARROW; k++) begin
                if (idx == CNT_W'(k))
                    coeff = COEFF_W'(word[k*NARROW_W +: NARROW_W]);
            end
        end else begin
            for (int k = 0; k < NUM_WIDE; k++) begin
                if (idx == CNT_W'(k))
                    coeff = word[k*COEFF_W +: COEFF_W];
            end
        end
    end

endmodule

// File: rtl/coeff_stream_buffer.sv
// Single-word coefficient buffer: loads a packed word, streams one coefficient
// per cycle under valid/ready, and reloads on the last beat without a bubble.
module coeff_stream_buffer
    import saber_coeff_pkg::clog2;
    import saber_coeff_pkg::MODE_WIDE;
    import saber_coeff_pkg::MODE_NARROW;
#(
    parameter int COEFF_W  = saber_coeff_pkg::COEFF_W,
    parameter int NARROW_W = saber_coeff_pkg::NARROW_W,
    parameter int NUM_WIDE = saber_coeff_pkg::NUM_WIDE,
    localparam int DATA_W     = NUM_WIDE * COEFF_W,
    localparam int NUM_NARROW = DATA_W / NARROW_W,
    localparam int CNT_W      =
        clog2(NUM_WIDE > NUM_NARROW ? NUM_WIDE : NUM_NARROW)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_narrow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] out_coeff,
    output logic [CNT_W-1:0]   out_idx,
    output logic               out_last
);

    logic [DATA_W-1:0]  word_q;
    logic               mode_q;
    logic [CNT_W-1:0]   idx_q;
    logic               full_q;
    logic [CNT_W-1:0]   last_idx;
    logic [COEFF_W-1:0] sel_coeff;
    logic               fire_out;
    logic               load;

    assign last_idx = (mode_q == MODE_NARROW) ? CNT_W'(NUM_NARROW - 1)
                                              : CNT_W'(NUM_WIDE - 1);

    assign out_valid = full_q;
    assign out_last  = full_q && (idx_q == last_idx);
    assign out_idx   = full_q ? idx_q : '0;
    assign out_coeff = full_q ? sel_coeff : '0;

    assign fire_out = out_valid && out_ready;
    // Accepting during the final beat keeps the stream gap-free.
    assign in_ready = !full_q || (fire_out && out_last);
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            mode_q <= MODE_WIDE;
            word_q <= '0;
        end else if (load) begin
            word_q <= in_data;
            mode_q <= in_narrow;
            idx_q  <= '0;
            full_q <= 1'b1;
        end else if (fire_out) begin
            if (out_last) begin
                full_q <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    coeff_select_mux #(
        .COEFF_W    (COEFF_W),
        .NARROW_W   (NARROW_W),
        .NUM_WIDE   (NUM_WIDE),
        .DATA_W     (DATA_W),
        .NUM_NARROW (NUM_NARROW),
        .CNT_W      (CNT_W)
    ) u_sel (
        .word  (word_q),
        .idx   (idx_q),
        .mode  (mode_q),
        .coeff (sel_coeff)
    );

endmodule

// File: tb/tb_coeff_stream_buffer.sv
// Scoreboard bench for coeff_stream_buffer: random words and stalls checked
// against a coefficient-list model of each accepted word.
module tb_coeff_stream_buffer;

    localparam int CW   = 13;
    localparam int NW   = 10;
    localparam int NWID = 13;
    localparam int DW   = 169;
    localparam int NNAR = 16;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_narrow = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   out_coeff;
    logic [CNTW-1:0] out_idx;
    logic            out_last;

    typedef struct {
        logic [CW-1:0] c;
        int            idx;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    rdy_pct  = 100;

    coeff_stream_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_narrow (in_narrow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor: pops one expected beat per handshake, checks stalls hold.
    logic [CW-1:0]   h_c;
    logic [CNTW-1:0] h_i;
    logic            h_l;
    bit              holding = 0;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            holding = 0;
        end else begin
            if (holding)
                chk("stall_stable", {out_valid, out_last, out_idx, out_coeff},
                    {1'b1, h_l, h_i, h_c});
            if (out_valid) begin
                if (out_ready) begin
                    holding = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("coeff", out_coeff, e.c);
                        chk("idx", out_idx, e.idx);
                        chk("last", out_last, e.last);
                    end
                end else begin
                    holding = 1;
                    h_c = out_coeff;
                    h_i = out_idx;
                    h_l = out_last;
                end
            end else begin
                holding = 0;
                chk("idle_zero", {out_coeff, out_idx, out_last}, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic send_word(input bit narrow, input int unsigned cs[16],
                             output bit overlapped);
        int n;
        int w;
        int t;
        logic [DW-1:0] d;
        beat_t b;
        n = narrow ? NNAR : NWID;
        w = narrow ? NW : CW;
        for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(1));
        for (int k = 0; k < n; k++)
            for (int i = 0; i < w; i++) d[k*w + i] = cs[k][i];
        in_data   = d;
        in_narrow = narrow;
        in_valid  = 1'b1;
        overlapped = 0;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        overlapped = out_valid && out_ready && out_last;
        for (int k = 0; k < n; k++) begin
            b.c    = cs[k][CW-1:0];
            b.idx  = k;
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {6{$urandom}};
        @(negedge clk);
        chk("first_beat_valid", out_valid, 1);
        chk("first_beat_idx", out_idx, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    initial begin
        int unsigned cs[16];
        bit ov;

        // Reset with a word offered: nothing may load.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = {6{32'hA5A5_A5A5}};
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_idx", out_idx, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("post_rst_no_load", out_valid, 0);
        idle(1);

        // Directed wide word: 1..13.
        for (int k = 0; k < 16; k++) cs[k] = k + 1;
        send_word(1'b0, cs, ov);
        drain();

        // Directed narrow word: 0x3F0..0x3FF.
        for (int k = 0; k < 16; k++) cs[k] = 32'h3F0 + k;
        send_word(1'b1, cs, ov);
        drain();

        // Back-to-back wide then narrow.
        for (int k = 0; k < 16; k++) cs[k] = $urandom_range(8191);
        send_word(1'b0, cs, ov);
        for (int k = 0; k < 16; k++) cs[k] = $urandom_range(1023);
        send_word(1'b1, cs, ov);
        chk("b2b_overlap", ov, 1);
        drain();

        // Random words with 50% consumer stalls.
        rdy_pct = 50;
        for (int w = 0; w < 100; w++) begin
            bit nar;
            nar = 1'($urandom_range(1));
            for (int k = 0; k < 16; k++)
                cs[k] = nar ? $urandom_range(1023) : $urandom_range(8191);
            send_word(nar, cs, ov);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end
        drain();

        // Reset while slot 5 of a wide word is on the output.
        rdy_pct = 100;
        idle(1);
        for (int k = 0; k < 16; k++) cs[k] = $urandom_range(8191);
        send_word(1'b0, cs, ov);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_idx5", out_idx, 5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst = 1'b0;
        idle(1);
        for (int k = 0; k < 16; k++) cs[k] = $urandom_range(1023);
        send_word(1'b1, cs, ov);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
